// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_frame_parser_if
//   Byte-stream input, host handshake and payload readback bundle for the parser.
//   Revision: 1.0
// ----------------------------------------------------------------------------
interface uart_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       frame_ack;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [7:0] frame_len;
  logic       rx_busy;
  logic       err_overflow;
  logic       err_timeout;

  modport master (
    output rx_data, rx_vld, frame_ack, rd_addr,
    input  rd_data, frame_valid, frame_len, rx_busy, err_overflow, err_timeout
  );

  modport slave (
    input  rx_data, rx_vld, frame_ack, rd_addr,
    output rd_data, frame_valid, frame_len, rx_busy, err_overflow, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_frame_parser
//   Extracts "&&" payload "&&" frames from a UART byte stream into a readable buffer.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module uart_frame_parser #(
  parameter int MAX_LEN     = 137,
  parameter int TIMEOUT_CLK = 100_000
) (
  input  wire logic          sys_clk,
  input  wire logic          sys_rst,
  uart_frame_parser_if.slave bus
);

  localparam logic [7:0]    AMP   = 8'h26;
  localparam int            AW    = $clog2(MAX_LEN + 1);
  localparam int            TW    = $clog2(TIMEOUT_CLK + 1);
  localparam logic [7:0]    MAXL  = 8'(MAX_LEN);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CLK - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SIGN1   = 3'd1,
    CONTENT = 3'd2,
    END1    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t        state_q;
  logic [7:0]    count_q;
  logic [7:0]    len_q;
  logic [7:0]    rd_q;
  logic [TW-1:0] tmo_q;
  logic          valid_q;
  logic          ov_q;
  logic          to_q;
  logic [7:0]    buf_q [0:MAX_LEN];

  logic is_amp;
  logic busy;
  logic wr_en;

  assign is_amp = (bus.rx_data == AMP);
  assign busy   = (state_q == SIGN1) || (state_q == CONTENT) || (state_q == END1);

  // One extra slot beyond MAX_LEN lets a full payload carry its pending terminator '&'.
  always_comb begin
    wr_en = 1'b0;
    if (bus.rx_vld) begin
      case (state_q)
        CONTENT: wr_en = (count_q < MAXL) || (is_amp && (count_q == MAXL));
        END1:    wr_en = !is_amp && (count_q <= MAXL);
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      buf_q[count_q[AW-1:0]] <= bus.rx_data;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_q <= 8'h00;
    end else begin
      rd_q <= (bus.rd_addr <= MAXL) ? buf_q[bus.rd_addr[AW-1:0]] : 8'h00;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      len_q   <= 8'd0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      ov_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      to_q <= 1'b0;
      if (bus.rx_vld) begin
        tmo_q <= '0;
      end
      if (busy && !bus.rx_vld) begin
        // A byte in the expiry cycle wins because this branch requires silence.
        if (tmo_q == TLAST) begin
          to_q    <= 1'b1;
          tmo_q   <= '0;
          state_q <= IDLE;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.rx_vld && is_amp) begin
              state_q <= SIGN1;
            end
          end
          SIGN1: begin
            if (bus.rx_vld) begin
              if (is_amp) begin
                count_q <= 8'd0;
                state_q <= CONTENT;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          CONTENT: begin
            if (bus.rx_vld) begin
              if (wr_en) begin
                count_q <= count_q + 8'd1;
                if (is_amp) begin
                  state_q <= END1;
                end
              end else begin
                ov_q    <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          END1: begin
            if (bus.rx_vld) begin
              if (is_amp) begin
                len_q   <= count_q - 8'd1;
                valid_q <= 1'b1;
                state_q <= HOLD;
              end else if (wr_en) begin
                count_q <= count_q + 8'd1;
                state_q <= CONTENT;
              end else begin
                ov_q    <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          HOLD: begin
            if (bus.frame_ack) begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.rd_data      = rd_q;
  assign bus.frame_valid  = valid_q;
  assign bus.frame_len    = len_q;
  assign bus.rx_busy      = busy;
  assign bus.err_overflow = ov_q;
  assign bus.err_timeout  = to_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_frame_parser
//   Vector table, directed corner sequences and a queue-based random reference model.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_frame_parser;

  localparam int         ML  = 4;
  localparam int         T   = 16;
  localparam logic [7:0] AMP = 8'h26;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_frame_parser_if bus ();

  uart_frame_parser #(.MAX_LEN(ML), .TIMEOUT_CLK(T)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [95:0] s;
    int          n;
    int          len;
    logic [31:0] p;
  } vec_t;

  vec_t tv [7];

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_vld  = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_vld  = 1'b0;
  endtask

  task automatic send_str(input logic [95:0] s, input int n);
    for (int i = 0; i < n; i++) send(s[8*(n-1-i) +: 8]);
  endtask

  task automatic ack();
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    @(negedge clk);
    bus.rd_addr = 8'(a);
    @(negedge clk);
    d = bus.rd_data;
  endtask

  // Reference model: the open frame is a queue of bytes received after "&&".
  bit         m_sign, m_inframe, m_held, m_valid;
  int         m_tcnt, m_len;
  logic [7:0] q [$];
  logic [7:0] m_mem   [0:ML];
  bit         m_known [0:ML];
  bit         e_ov, e_to, e_rd_known;
  logic [7:0] e_rd;

  task automatic m_reset();
    m_sign = 0; m_inframe = 0; m_held = 0; m_valid = 0;
    m_tcnt = 0; m_len = 0; q.delete();
    for (int i = 0; i <= ML; i++) m_known[i] = 0;
  endtask

  task automatic m_push(input logic [7:0] b);
    m_mem[q.size()]   = b;
    m_known[q.size()] = 1;
    q.push_back(b);
  endtask

  task automatic m_frame_byte(input logic [7:0] b);
    int s;
    s = q.size();
    if (s > 0 && q[s-1] == AMP) begin
      if (b == AMP) begin
        m_held = 1; m_valid = 1; m_len = s - 1; m_sign = 0; m_inframe = 0;
      end else if (s <= ML) m_push(b);
      else begin e_ov = 1; m_sign = 0; m_inframe = 0; end
    end else begin
      if (s < ML || (s == ML && b == AMP)) m_push(b);
      else begin e_ov = 1; m_sign = 0; m_inframe = 0; end
    end
  endtask

  task automatic m_step(input bit vld, input logic [7:0] b, input bit a, input logic [7:0] addr);
    e_ov = 0; e_to = 0;
    if (addr <= ML) begin e_rd_known = m_known[addr]; e_rd = m_mem[addr]; end
    else begin e_rd_known = 1; e_rd = 8'h00; end
    if (m_held) begin
      if (a) begin m_held = 0; m_valid = 0; end
    end else if (m_sign || m_inframe) begin
      if (!vld) begin
        m_tcnt++;
        if (m_tcnt == T) begin e_to = 1; m_sign = 0; m_inframe = 0; end
      end else begin
        m_tcnt = 0;
        if (!m_inframe) begin
          if (b == AMP) begin m_inframe = 1; q.delete(); end
          else m_sign = 0;
        end else m_frame_byte(b);
      end
    end else if (vld && b == AMP) begin
      m_sign = 1; m_tcnt = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [7:0] b, ad;
    bit v, a;
    int gap;

    tv[0] = '{s: 96'("&&AB&&"),   n: 6, len: 2, p: 32'("AB")};
    tv[1] = '{s: 96'("&&A&B&&"),  n: 7, len: 3, p: 32'("A&B")};
    tv[2] = '{s: 96'("&&&&"),     n: 4, len: 0, p: 32'h0};
    tv[3] = '{s: 96'("&&ABCD&&"), n: 8, len: 4, p: 32'("ABCD")};
    tv[4] = '{s: 96'("xy&&&&"),   n: 6, len: 0, p: 32'h0};
    tv[5] = '{s: 96'("&x&&Q&&"),  n: 7, len: 1, p: 32'("Q")};
    tv[6] = '{s: 96'("&&AB&C&&"), n: 8, len: 4, p: 32'("AB&C")};

    rst = 1'b1;
    bus.rx_vld = 1'b0; bus.rx_data = 8'h00; bus.frame_ack = 1'b0; bus.rd_addr = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset frame_valid", bus.frame_valid, 0);
    chk("reset frame_len", bus.frame_len, 0);
    chk("reset rx_busy", bus.rx_busy, 0);
    chk("reset err_overflow", bus.err_overflow, 0);
    chk("reset err_timeout", bus.err_timeout, 0);
    chk("reset rd_data", bus.rd_data, 0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) begin
      send_str(tv[k].s, tv[k].n);
      chk($sformatf("vec%0d frame_valid", k), bus.frame_valid, 1);
      chk($sformatf("vec%0d frame_len", k), bus.frame_len, tv[k].len);
      chk($sformatf("vec%0d rx_busy", k), bus.rx_busy, 0);
      for (int j = 0; j < tv[k].len; j++) begin
        rd(j, d);
        chk($sformatf("vec%0d payload[%0d]", k, j), d, tv[k].p[8*(tv[k].len-1-j) +: 8]);
      end
      rd(ML + 1, d);
      chk($sformatf("vec%0d rd beyond MAX_LEN", k), d, 0);
      ack();
      chk($sformatf("vec%0d valid after ack", k), bus.frame_valid, 0);
    end

    // Content overflow on the fifth payload byte
    send_str(96'("&&ABCD"), 6);
    @(negedge clk); bus.rx_vld = 1'b1; bus.rx_data = "E";
    @(negedge clk); bus.rx_vld = 1'b0;
    chk("overflow pulse", bus.err_overflow, 1);
    chk("overflow rx_busy", bus.rx_busy, 0);
    chk("overflow frame_valid", bus.frame_valid, 0);
    @(negedge clk);
    chk("overflow pulse width", bus.err_overflow, 0);

    // Silence expiry
    send_str(96'("&&AB"), 4);
    repeat (T - 1) @(negedge clk);
    chk("timeout early", bus.err_timeout, 0);
    chk("timeout early busy", bus.rx_busy, 1);
    @(negedge clk);
    chk("timeout pulse", bus.err_timeout, 1);
    chk("timeout busy", bus.rx_busy, 0);
    @(negedge clk);
    chk("timeout pulse width", bus.err_timeout, 0);

    // Byte arriving in the expiry cycle keeps the frame alive
    send_str(96'("&&AB"), 4);
    repeat (T - 2) @(negedge clk);
    send("C");
    chk("late byte no timeout", bus.err_timeout, 0);
    chk("late byte busy", bus.rx_busy, 1);
    send_str(96'("&&"), 2);
    chk("late byte frame_valid", bus.frame_valid, 1);
    chk("late byte frame_len", bus.frame_len, 3);
    rd(2, d);
    chk("late byte payload[2]", d, 8'h43);
    ack();

    // Traffic during HOLD is discarded
    send_str(96'("&&AB&&"), 6);
    send_str(96'("&&XY&&"), 6);
    chk("hold frame_len", bus.frame_len, 2);
    chk("hold frame_valid", bus.frame_valid, 1);
    rd(0, d); chk("hold payload[0]", d, 8'h41);
    rd(1, d); chk("hold payload[1]", d, 8'h42);
    ack();
    chk("hold ack valid", bus.frame_valid, 0);
    chk("hold ack busy", bus.rx_busy, 0);

    // Asynchronous reset mid-frame
    send_str(96'("&&AB"), 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst frame_len", bus.frame_len, 0);
    chk("midrst rx_busy", bus.rx_busy, 0);
    chk("midrst rd_data", bus.rd_data, 0);
    chk("midrst frame_valid", bus.frame_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    send_str(96'("&&Z&&"), 5);
    chk("postrst frame_len", bus.frame_len, 1);
    rd(0, d);
    chk("postrst payload[0]", d, 8'h5A);
    ack();

    // Randomized traffic against the reference model
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_reset();
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (gap > 0) begin
        v = 0; gap--;
      end else if ($urandom_range(0, 99) < 3) begin
        v = 0; gap = $urandom_range(T - 3, T + 2);
      end else begin
        v = ($urandom_range(0, 1) == 1);
      end
      b  = ($urandom_range(0, 1) == 1) ? AMP : 8'(8'h41 + $urandom_range(0, 3));
      a  = ($urandom_range(0, 99) < 15);
      ad = 8'($urandom_range(0, ML + 2));
      bus.rx_vld = v; bus.rx_data = b; bus.frame_ack = a; bus.rd_addr = ad;
      m_step(v, b, a, ad);
      @(posedge clk);
      #1;
      chk("rnd frame_valid", bus.frame_valid, m_valid);
      chk("rnd frame_len", bus.frame_len, m_len);
      chk("rnd rx_busy", bus.rx_busy, (m_sign || m_inframe));
      chk("rnd err_overflow", bus.err_overflow, e_ov);
      chk("rnd err_timeout", bus.err_timeout, e_to);
      if (e_rd_known) chk("rnd rd_data", bus.rd_data, e_rd);
    end
    bus.rx_vld = 1'b0; bus.frame_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
